// File: rtl/mac_operand_buffer_pkg.sv
// Shared types and width helpers for the MAC operand buffer and its address generator.
package mac_mem_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  typedef logic bank_sel_t;

  // Index width that never collapses to zero for degenerate (size 1) dimensions.
  function automatic int clog2_min1(input int value);
    return (value > 2) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/mac_operand_buffer_if.sv
// Host-load, operand-stream and C-buffer signals of the MAC operand buffer.
interface mac_operand_buffer_if
  import mac_mem_pkg::*;
#(
  parameter int param_M            = 4,
  parameter int param_K            = 4,
  parameter int param_N            = 4,
  parameter int DATA_WIDTH_INITIAL = 8,
  parameter int DATA_WIDTH_FINAL   = 2 * DATA_WIDTH_INITIAL
);
  localparam int IDX_W = clog2_min1(param_M * param_N);

  logic                                                 ab_load_valid;
  logic                                                 ab_load_ready;
  logic [param_M*param_K*DATA_WIDTH_INITIAL-1:0]        a_data_in;
  logic [param_K*param_N*DATA_WIDTH_INITIAL-1:0]        b_data_in;
  logic                                                 start;
  logic                                                 busy;
  logic                                                 done;
  logic                                                 op_valid;
  logic                                                 op_ready;
  logic [DATA_WIDTH_INITIAL-1:0]                        a_op;
  logic [DATA_WIDTH_INITIAL-1:0]                        b_op;
  logic                                                 op_last;
  logic [IDX_W-1:0]                                     op_c_idx;
  logic                                                 c_we;
  logic [IDX_W-1:0]                                     c_addr;
  logic [DATA_WIDTH_FINAL-1:0]                          c_data_in;
  logic                                                 c_re;
  logic [param_M*param_N*DATA_WIDTH_FINAL-1:0]          c_data_out;
  logic                                                 c_out_valid;

  modport master (
    output ab_load_valid, a_data_in, b_data_in, start, op_ready,
           c_we, c_addr, c_data_in, c_re,
    input  ab_load_ready, busy, done, op_valid, a_op, b_op, op_last,
           op_c_idx, c_data_out, c_out_valid
  );

  modport slave (
    input  ab_load_valid, a_data_in, b_data_in, start, op_ready,
           c_we, c_addr, c_data_in, c_re,
    output ab_load_ready, busy, done, op_valid, a_op, b_op, op_last,
           op_c_idx, c_data_out, c_out_valid
  );

endinterface

// File: rtl/mac_operand_buffer_addr_gen.sv
// Stream FSM and i/j/k walker: k innermost, then j, then i; one beat per accepted handshake.
module mac_operand_addr_gen
  import mac_mem_pkg::*;
#(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4,
  localparam int IW    = clog2_min1(M),
  localparam int JW    = clog2_min1(N),
  localparam int KW    = clog2_min1(K),
  localparam int AW    = clog2_min1(M * K),
  localparam int BW    = clog2_min1(K * N),
  localparam int IDX_W = clog2_min1(M * N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             bank_avail,
  input  logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic             op_valid,
  output logic             op_last,
  output logic [IDX_W-1:0] op_c_idx,
  output logic             adv,
  output logic [AW-1:0]    a_idx_nxt,
  output logic [BW-1:0]    b_idx_nxt,
  output logic             release_bank
);

  localparam logic [0:0]    ST_IDLE   = IDLE;
  localparam logic [0:0]    ST_STREAM = STREAM;
  localparam logic [IW-1:0] I_MAX     = IW'(M - 1);
  localparam logic [JW-1:0] J_MAX     = JW'(N - 1);
  localparam logic [KW-1:0] K_MAX     = KW'(K - 1);

  logic [0:0]       state_r;
  logic [IW-1:0]    i_r, i_nxt_s;
  logic [JW-1:0]    j_r, j_nxt_s;
  logic [KW-1:0]    k_r, k_nxt_s;
  logic             busy_r, done_r, op_valid_r, op_last_r;
  logic [IDX_W-1:0] op_c_idx_r;
  logic             start_ok_s, fire_s, last_beat_s, final_s;

  assign start_ok_s  = (state_r == ST_IDLE) && start && bank_avail;
  assign fire_s      = op_valid_r && op_ready;
  assign last_beat_s = (i_r == I_MAX) && (j_r == J_MAX) && (k_r == K_MAX);
  assign final_s     = fire_s && last_beat_s;
  assign adv         = start_ok_s || (fire_s && !last_beat_s);

  // Next counter position; held whenever the current beat is not consumed.
  always_comb begin
    i_nxt_s = i_r;
    j_nxt_s = j_r;
    k_nxt_s = k_r;
    if (start_ok_s) begin
      i_nxt_s = '0;
      j_nxt_s = '0;
      k_nxt_s = '0;
    end else if (fire_s && !last_beat_s) begin
      if (k_r == K_MAX) begin
        k_nxt_s = '0;
        if (j_r == J_MAX) begin
          j_nxt_s = '0;
          i_nxt_s = i_r + IW'(1'b1);
        end else begin
          j_nxt_s = j_r + JW'(1'b1);
        end
      end else begin
        k_nxt_s = k_r + KW'(1'b1);
      end
    end else begin
      k_nxt_s = k_r;
    end
  end

  // Flat element indices for the next beat, used by the top to prefetch operands.
  always_comb begin
    a_idx_nxt = AW'(int'(i_nxt_s) * K + int'(k_nxt_s));
    b_idx_nxt = BW'(int'(k_nxt_s) * N + int'(j_nxt_s));
  end

  // FSM, counters and registered stream outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      i_r        <= '0;
      j_r        <= '0;
      k_r        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      op_valid_r <= 1'b0;
      op_last_r  <= 1'b0;
      op_c_idx_r <= '0;
    end else begin
      i_r    <= i_nxt_s;
      j_r    <= j_nxt_s;
      k_r    <= k_nxt_s;
      done_r <= final_s;
      if (adv) begin
        op_last_r  <= (k_nxt_s == K_MAX);
        op_c_idx_r <= IDX_W'(int'(i_nxt_s) * N + int'(j_nxt_s));
      end
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_r    <= ST_STREAM;
            busy_r     <= 1'b1;
            op_valid_r <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (final_s) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            op_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          op_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign op_valid     = op_valid_r;
  assign op_last      = op_last_r;
  assign op_c_idx     = op_c_idx_r;
  assign release_bank = final_s;

endmodule

// File: rtl/mac_operand_buffer.sv
// Ping-pong A/B operand banks, bank flags and the C result buffer around the stream address generator.
module mac_operand_buffer
  import mac_mem_pkg::*;
#(
  parameter int param_M            = 4,
  parameter int param_K            = 4,
  parameter int param_N            = 4,
  parameter int DATA_WIDTH_INITIAL = 8,
  parameter int DATA_WIDTH_FINAL   = 2 * DATA_WIDTH_INITIAL
) (
  input logic                  clk,
  input logic                  rstn,
  mac_operand_buffer_if.slave  bus
);

  localparam int DWI   = DATA_WIDTH_INITIAL;
  localparam int DWF   = DATA_WIDTH_FINAL;
  localparam int MK    = param_M * param_K;
  localparam int KN    = param_K * param_N;
  localparam int MN    = param_M * param_N;
  localparam int AW    = clog2_min1(MK);
  localparam int BW    = clog2_min1(KN);

  logic [DWI-1:0]    bank_a_r [2][MK];
  logic [DWI-1:0]    bank_b_r [2][KN];
  logic [1:0]        bank_full_r;
  bank_sel_t         wr_sel_r, rd_sel_r;
  logic [DWI-1:0]    a_op_r, b_op_r;
  logic [DWF-1:0]    buffer_c_r [MN];
  logic [MN*DWF-1:0] c_data_out_r;
  logic              c_out_valid_r;

  logic              load_fire_s, adv_s, release_s;
  logic [AW-1:0]     a_idx_nxt_s;
  logic [BW-1:0]     b_idx_nxt_s;

  assign bus.ab_load_ready = !bank_full_r[wr_sel_r];
  assign load_fire_s       = bus.ab_load_valid && !bank_full_r[wr_sel_r];

  mac_operand_addr_gen #(
    .M (param_M),
    .K (param_K),
    .N (param_N)
  ) u_addr_gen (
    .clk          (clk),
    .rstn         (rstn),
    .start        (bus.start),
    .bank_avail   (bank_full_r[rd_sel_r]),
    .op_ready     (bus.op_ready),
    .busy         (bus.busy),
    .done         (bus.done),
    .op_valid     (bus.op_valid),
    .op_last      (bus.op_last),
    .op_c_idx     (bus.op_c_idx),
    .adv          (adv_s),
    .a_idx_nxt    (a_idx_nxt_s),
    .b_idx_nxt    (b_idx_nxt_s),
    .release_bank (release_s)
  );

  // Bank storage: a load always targets the empty write-side bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < MK; e++) bank_a_r[b][e] <= '0;
        for (int e = 0; e < KN; e++) bank_b_r[b][e] <= '0;
      end
    end else if (load_fire_s) begin
      for (int e = 0; e < MK; e++) bank_a_r[wr_sel_r][e] <= bus.a_data_in[e*DWI +: DWI];
      for (int e = 0; e < KN; e++) bank_b_r[wr_sel_r][e] <= bus.b_data_in[e*DWI +: DWI];
    end
  end

  // Full flags and bank pointers; a load and a release never hit the same bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_full_r <= 2'b00;
      wr_sel_r    <= 1'b0;
      rd_sel_r    <= 1'b0;
    end else begin
      if (load_fire_s) begin
        bank_full_r[wr_sel_r] <= 1'b1;
        wr_sel_r              <= ~wr_sel_r;
      end
      if (release_s) begin
        bank_full_r[rd_sel_r] <= 1'b0;
        rd_sel_r              <= ~rd_sel_r;
      end
    end
  end

  // Operand registers load the next beat's elements alongside the counter step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_op_r <= '0;
      b_op_r <= '0;
    end else if (adv_s) begin
      a_op_r <= bank_a_r[rd_sel_r][a_idx_nxt_s];
      b_op_r <= bank_b_r[rd_sel_r][b_idx_nxt_s];
    end
  end

  // C buffer: snapshot reads see contents from before a same-cycle write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < MN; e++) buffer_c_r[e] <= '0;
      c_data_out_r  <= '0;
      c_out_valid_r <= 1'b0;
    end else begin
      c_out_valid_r <= bus.c_re;
      if (bus.c_re) begin
        for (int e = 0; e < MN; e++) c_data_out_r[e*DWF +: DWF] <= buffer_c_r[e];
      end
      if (bus.c_we && (int'(bus.c_addr) < MN)) begin
        buffer_c_r[bus.c_addr] <= bus.c_data_in;
      end
    end
  end

  assign bus.a_op        = a_op_r;
  assign bus.b_op        = b_op_r;
  assign bus.c_data_out  = c_data_out_r;
  assign bus.c_out_valid = c_out_valid_r;

endmodule

// File: tb/tb_mac_operand_buffer.sv
// Self-checking bench: queue-based reference model checked every cycle, plus directed tables/sequences.
module tb_mac_operand_buffer;

  localparam int M = 2, K = 2, N = 2, DWI = 8, DWF = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mac_operand_buffer_if #(.param_M(M), .param_K(K), .param_N(N),
                          .DATA_WIDTH_INITIAL(DWI), .DATA_WIDTH_FINAL(DWF)) bus ();

  mac_operand_buffer #(.param_M(M), .param_K(K), .param_N(N),
                       .DATA_WIDTH_INITIAL(DWI), .DATA_WIDTH_FINAL(DWF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] b;} mats_t;
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic last; logic [1:0] idx;} beat_t;
  typedef struct {logic [7:0] a; logic [7:0] b; logic last; logic [1:0] idx;} vec_t;

  int checks = 0;
  int failures = 0;

  mats_t       full_q[$];
  beat_t       beats_q[$];
  logic        m_busy, m_done, m_cvalid;
  logic [15:0] c_mem[4];
  logic [63:0] m_cout;
  bit          seen_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] elem(input logic [31:0] v, input int e);
    return v[e*8 +: 8];
  endfunction

  task automatic model_clear();
    full_q.delete();
    beats_q.delete();
    m_busy = 1'b0; m_done = 1'b0; m_cvalid = 1'b0; m_cout = '0;
    for (int e = 0; e < 4; e++) c_mem[e] = '0;
  endtask

  task automatic clear_inputs();
    bus.ab_load_valid = 1'b0; bus.a_data_in = '0; bus.b_data_in = '0;
    bus.start = 1'b0; bus.op_ready = 1'b1;
    bus.c_we = 1'b0; bus.c_addr = '0; bus.c_data_in = '0; bus.c_re = 1'b0;
  endtask

  // Every C element is a sum over k; emit the (A[i][k], B[k][j]) terms in i, j, k order.
  task automatic gen_beats(input mats_t m);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < K; k++)
          beats_q.push_back('{a: elem(m.a, i*K+k), b: elem(m.b, k*N+j),
                              last: (k == K-1), idx: 2'(i*N+j)});
  endtask

  task automatic step();
    bit ld_ok, fire, st_ok;
    ld_ok = bus.ab_load_valid && (full_q.size() < 2);
    fire  = m_busy && bus.op_ready;
    st_ok = !m_busy && bus.start && (full_q.size() > 0);
    m_done = 1'b0;
    if (fire) begin
      void'(beats_q.pop_front());
      if (beats_q.size() == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        void'(full_q.pop_front());
      end
    end
    if (st_ok) begin
      gen_beats(full_q[0]);
      m_busy = 1'b1;
    end
    if (ld_ok) full_q.push_back('{a: bus.a_data_in, b: bus.b_data_in});
    if (bus.c_re) for (int e = 0; e < 4; e++) m_cout[e*16 +: 16] = c_mem[e];
    m_cvalid = bus.c_re;
    if (bus.c_we) c_mem[bus.c_addr] = bus.c_data_in;
    @(posedge clk); #1;
    check("op_valid", bus.op_valid, m_busy);
    check("busy", bus.busy, m_busy);
    check("done", bus.done, m_done);
    check("ab_load_ready", bus.ab_load_ready, full_q.size() < 2);
    check("c_out_valid", bus.c_out_valid, m_cvalid);
    check("c_data_out", bus.c_data_out, m_cout);
    if (m_busy) begin
      check("a_op", bus.a_op, beats_q[0].a);
      check("b_op", bus.b_op, beats_q[0].b);
      check("op_last", bus.op_last, beats_q[0].last);
      check("op_c_idx", bus.op_c_idx, beats_q[0].idx);
    end
    if (m_done) seen_done = 1'b1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    bus.a_data_in = a; bus.b_data_in = b; bus.ab_load_valid = 1'b1;
    step();
    bus.ab_load_valid = 1'b0;
  endtask

  task automatic run_stream();
    seen_done = 1'b0;
    bus.op_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 0; n < 60 && !seen_done; n++) step();
    check("stream_done", seen_done, 1'b1);
  endtask

  vec_t tbl[8];
  int   accepted, valid_cycles, stall;

  initial begin
    tbl[0] = '{8'd1, 8'd5, 1'b0, 2'd0}; tbl[1] = '{8'd2, 8'd7, 1'b1, 2'd0};
    tbl[2] = '{8'd1, 8'd6, 1'b0, 2'd1}; tbl[3] = '{8'd2, 8'd8, 1'b1, 2'd1};
    tbl[4] = '{8'd3, 8'd5, 1'b0, 2'd2}; tbl[5] = '{8'd4, 8'd7, 1'b1, 2'd2};
    tbl[6] = '{8'd3, 8'd6, 1'b0, 2'd3}; tbl[7] = '{8'd4, 8'd8, 1'b1, 2'd3};

    clear_inputs();
    model_clear();
    #12;
    check("rst_op_valid", bus.op_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_load_ready", bus.ab_load_ready, 1'b1);
    check("rst_a_op", bus.a_op, 8'd0);
    check("rst_c_out_valid", bus.c_out_valid, 1'b0);
    check("rst_c_data_out", bus.c_data_out, 64'd0);
    rstn = 1'b1;

    // Basic stream, compared against the fixed table.
    load(32'h04030201, 32'h08070605);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int t = 0; t < 8; t++) begin
      check($sformatf("tbl_a_%0d", t), bus.a_op, tbl[t].a);
      check($sformatf("tbl_b_%0d", t), bus.b_op, tbl[t].b);
      check($sformatf("tbl_last_%0d", t), bus.op_last, tbl[t].last);
      check($sformatf("tbl_idx_%0d", t), bus.op_c_idx, tbl[t].idx);
      check($sformatf("tbl_done_%0d", t), bus.done, 1'b0);
      step();
    end
    check("tbl_done_pulse", bus.done, 1'b1);
    check("tbl_valid_after", bus.op_valid, 1'b0);
    step();

    // Back-pressure for two cycles on the third beat.
    load(32'h04030201, 32'h08070605);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    accepted = 0; valid_cycles = 0; stall = 2;
    for (int n = 0; n < 40 && !bus.done; n++) begin
      bus.op_ready = !(accepted == 2 && stall > 0);
      if (!bus.op_ready) begin
        stall--;
        check("stall_a_held", bus.a_op, 8'd1);
        check("stall_b_held", bus.b_op, 8'd6);
      end
      if (bus.op_valid) valid_cycles++;
      if (bus.op_valid && bus.op_ready) accepted++;
      step();
    end
    check("stall_valid_cycles", 64'(valid_cycles), 64'd10);
    check("stall_accepted", 64'(accepted), 64'd8);
    bus.op_ready = 1'b1;
    step();

    // Ping-pong: second load mid-stream, third blocked until the first bank frees.
    load(32'h0C0B0A09, 32'h100F0E0D);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    load(32'h18171615, 32'h1C1B1A19);
    check("pp_ready_both_full", bus.ab_load_ready, 1'b0);
    bus.a_data_in = 32'h24232221; bus.b_data_in = 32'h28272625; bus.ab_load_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (bus.done) begin
        check("pp_ready_at_done", bus.ab_load_ready, 1'b1);
        break;
      end
      check("pp_ready_blocked", bus.ab_load_ready, 1'b0);
      step();
    end
    step();
    bus.ab_load_valid = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("pp_bank1_first_a", bus.a_op, 8'h15);
    check("pp_bank1_first_b", bus.b_op, 8'h19);
    seen_done = 1'b0;
    for (int n = 0; n < 20 && !seen_done; n++) step();
    check("pp_bank1_done", seen_done, 1'b1);
    run_stream();
    step();

    // Start with both banks empty is ignored.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("empty_busy", bus.busy, 1'b0);
    check("empty_valid", bus.op_valid, 1'b0);
    step();
    load(32'h44332211, 32'h88776655);
    run_stream();

    // C buffer: same-cycle write and read returns the old contents.
    bus.c_we = 1'b1; bus.c_addr = 2'd3; bus.c_data_in = 16'h1234; bus.c_re = 1'b1;
    step();
    bus.c_we = 1'b0;
    check("c_rw_old", bus.c_data_out[63:48], 16'h0000);
    check("c_rw_valid", bus.c_out_valid, 1'b1);
    step();
    bus.c_re = 1'b0;
    check("c_read_new", bus.c_data_out[63:48], 16'h1234);
    step();
    check("c_valid_pulse", bus.c_out_valid, 1'b0);
    check("c_hold", bus.c_data_out[63:48], 16'h1234);

    // Reset in the middle of a stream.
    load(32'h04030201, 32'h08070605);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 0; n < 4; n++) step();
    check("mid_beat5_a", bus.a_op, 8'd3);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", bus.op_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_ready", bus.ab_load_ready, 1'b1);
    model_clear();
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("post_rst_start_ignored", bus.busy, 1'b0);
    step();
    check("post_rst_no_done", bus.done, 1'b0);
    load(32'hA0B0C0D0, 32'h01020304);
    run_stream();

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      bus.ab_load_valid = ($urandom % 3) == 0;
      bus.a_data_in     = $urandom;
      bus.b_data_in     = $urandom;
      bus.start         = ($urandom % 4) == 0;
      bus.op_ready      = ($urandom % 4) != 0;
      bus.c_we          = ($urandom % 3) == 0;
      bus.c_addr        = 2'($urandom % 4);
      bus.c_data_in     = 16'($urandom);
      bus.c_re          = ($urandom % 5) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
